hx8357_bus_writer: RTL and testbench

- Downstream stage of the HX8357 init/command sequencer.
- Takes one 16-bit word plus a single-cycle cmd or data strobe and executes one 8080-style parallel write cycle on the HX8357 pins (CSX, DCX, WRX, RDX, D[15:0]) with programmable phase timing.
- Returns a single-cycle transmission_cmpl pulse when the write completes; this is the pulse the sequencer waits on before issuing the next word.

---
 rtl/hx8357_pkg.sv | 24 ++
 rtl/hx8357_bus_writer.sv | 144 ++++++++++++++
 tb/tb_hx8357_bus_writer.sv | 313 +++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/hx8357_pkg.sv
// Shared types for the HX8357 sequencer and bus writer: writer states, DCX encodings, bus word.
// Pure declarations, no timing; the phase_load helper turns a phase length into a counter preload.
package hx8357_pkg;

   typedef enum logic [2:0] {
      IDLE    = 3'd0,
      SETUP   = 3'd1,
      WR_LOW  = 3'd2,
      WR_HIGH = 3'd3,
      HOLD    = 3'd4,
      DONE    = 3'd5
   } wr_state_t;

   localparam logic DCX_CMD  = 1'b0;
   localparam logic DCX_DATA = 1'b1;

   typedef logic [15:0] bus_word_t;

   // Down-counter preload: a phase of N clocks starts at N-1 and exits on zero.
   function automatic logic [7:0] phase_load(input int n);
      return 8'(n - 1);
   endfunction

endpackage

// File: rtl/hx8357_bus_writer.sv
// One 8080-style write per cmd/data strobe; cmpl S+L+H+Hd+1 clocks after the accepting edge.
// Strobes are accepted only in IDLE or DONE; any other strobe is dropped and flags protocol_err.
module hx8357_bus_writer
   import hx8357_pkg::*;
#(
   parameter int CS_SETUP_CYCLES = 1,
   parameter int WR_LOW_CYCLES   = 2,
   parameter int WR_HIGH_CYCLES  = 2,
   parameter int CS_HOLD_CYCLES  = 1
) (
   input  logic      clk,
   input  logic      nres,
   input  bus_word_t data_lines,
   input  logic      cmd,
   input  logic      data,
   output logic      transmission_cmpl,
   output logic      busy,
   output logic      protocol_err,
   output logic      lcd_csx,
   output logic      lcd_dcx,
   output logic      lcd_wrx,
   output logic      lcd_rdx,
   output bus_word_t lcd_d
);

   if (CS_SETUP_CYCLES < 1 || CS_SETUP_CYCLES > 255 ||
       WR_LOW_CYCLES   < 1 || WR_LOW_CYCLES   > 255 ||
       WR_HIGH_CYCLES  < 1 || WR_HIGH_CYCLES  > 255 ||
       CS_HOLD_CYCLES  < 1 || CS_HOLD_CYCLES  > 255) begin : g_bad_param
      $error("hx8357_bus_writer: every phase length must be within 1..255");
   end

   wr_state_t  r_state;
   logic [7:0] r_cnt;
   logic       r_csx;
   logic       r_dcx;
   logic       r_wrx;
   bus_word_t  r_d;
   logic       r_cmpl;
   logic       r_busy;
   logic       r_err;

   wr_state_t  w_next_state;
   logic [7:0] w_next_cnt;
   logic       w_strobe;
   logic       w_accept;
   logic       w_err_set;
   logic       w_cnt_zero;

   always_comb begin
      w_strobe     = cmd | data;
      w_accept     = w_strobe && (r_state == IDLE || r_state == DONE);
      w_err_set    = (w_strobe && !w_accept) || (cmd && data);
      w_cnt_zero   = (r_cnt == 8'd0);
      w_next_state = r_state;
      w_next_cnt   = r_cnt;
      case (r_state)
         IDLE, DONE: begin
            if (w_accept) begin
               w_next_state = SETUP;
               w_next_cnt   = phase_load(CS_SETUP_CYCLES);
            end else begin
               w_next_state = IDLE;
               w_next_cnt   = 8'd0;
            end
         end
         SETUP: begin
            if (w_cnt_zero) begin
               w_next_state = WR_LOW;
               w_next_cnt   = phase_load(WR_LOW_CYCLES);
            end else begin
               w_next_cnt = r_cnt - 8'd1;
            end
         end
         WR_LOW: begin
            if (w_cnt_zero) begin
               w_next_state = WR_HIGH;
               w_next_cnt   = phase_load(WR_HIGH_CYCLES);
            end else begin
               w_next_cnt = r_cnt - 8'd1;
            end
         end
         WR_HIGH: begin
            if (w_cnt_zero) begin
               w_next_state = HOLD;
               w_next_cnt   = phase_load(CS_HOLD_CYCLES);
            end else begin
               w_next_cnt = r_cnt - 8'd1;
            end
         end
         HOLD: begin
            if (w_cnt_zero) begin
               w_next_state = DONE;
               w_next_cnt   = 8'd0;
            end else begin
               w_next_cnt = r_cnt - 8'd1;
            end
         end
         default: begin
            w_next_state = IDLE;
            w_next_cnt   = 8'd0;
         end
      endcase
   end

   // Pin levels are decoded from the next state so every output leaves a flop.
   always_ff @(posedge clk or negedge nres) begin
      if (!nres) begin
         r_state <= IDLE;
         r_cnt   <= 8'd0;
         r_csx   <= 1'b1;
         r_dcx   <= 1'b1;
         r_wrx   <= 1'b1;
         r_d     <= '0;
         r_cmpl  <= 1'b0;
         r_busy  <= 1'b0;
         r_err   <= 1'b0;
      end else begin
         r_state <= w_next_state;
         r_cnt   <= w_next_cnt;
         r_csx   <= (w_next_state == IDLE) || (w_next_state == DONE);
         r_wrx   <= (w_next_state != WR_LOW);
         r_cmpl  <= (w_next_state == DONE);
         r_busy  <= (w_next_state != IDLE);
         if (w_accept) begin
            r_d   <= data_lines;
            r_dcx <= (data && !cmd) ? DCX_DATA : DCX_CMD;
         end
         if (w_err_set) begin
            r_err <= 1'b1;
         end
      end
   end

   assign transmission_cmpl = r_cmpl;
   assign busy              = r_busy;
   assign protocol_err      = r_err;
   assign lcd_csx           = r_csx;
   assign lcd_dcx           = r_dcx;
   assign lcd_wrx           = r_wrx;
   assign lcd_rdx           = 1'b1;
   assign lcd_d             = r_d;

endmodule

// File: tb/tb_hx8357_bus_writer.sv
// Bench for hx8357_bus_writer: default-timing instance plus a slow-timing instance (S=3,L=5,H=4,Hd=2).
module tb_hx8357_bus_writer;
   import hx8357_pkg::*;

   logic      clk = 1'b0;
   logic      nres = 1'b0;
   bus_word_t data_lines = '0;
   logic      cmd = 1'b0, data = 1'b0;
   logic      b_cmd = 1'b0, b_data = 1'b0;

   logic      cmpl, busy, err, csx, dcx, wrx, rdx;
   bus_word_t d;
   logic      b_cmpl, b_busy, b_err, b_csx, b_dcx, b_wrx, b_rdx;
   bus_word_t b_d;

   int n_cmp = 0;
   int n_bad = 0;

   always #5 clk = ~clk;

   hx8357_bus_writer u_dut (
      .clk(clk), .nres(nres), .data_lines(data_lines), .cmd(cmd), .data(data),
      .transmission_cmpl(cmpl), .busy(busy), .protocol_err(err),
      .lcd_csx(csx), .lcd_dcx(dcx), .lcd_wrx(wrx), .lcd_rdx(rdx), .lcd_d(d)
   );

   hx8357_bus_writer #(
      .CS_SETUP_CYCLES(3), .WR_LOW_CYCLES(5), .WR_HIGH_CYCLES(4), .CS_HOLD_CYCLES(2)
   ) u_dut_slow (
      .clk(clk), .nres(nres), .data_lines(data_lines), .cmd(b_cmd), .data(b_data),
      .transmission_cmpl(b_cmpl), .busy(b_busy), .protocol_err(b_err),
      .lcd_csx(b_csx), .lcd_dcx(b_dcx), .lcd_wrx(b_wrx), .lcd_rdx(b_rdx), .lcd_d(b_d)
   );

   // Expected {csx, wrx, cmpl} k cycles after the accepting edge, from the phase lengths alone.
   function automatic logic [2:0] wave(input int k, input int s, input int l, input int h, input int hd);
      int total;
      logic [2:0] r;
      total = s + l + h + hd + 1;
      r[2] = !(k >= 1 && k < total);
      r[1] = !(k > s && k <= s + l);
      r[0] = (k == total);
      return r;
   endfunction

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic test_reset();
      #12;
      n_cmp++;
      if ({csx, dcx, wrx, rdx, d, cmpl, busy, err} !== {4'b1111, 16'h0000, 3'b000}) begin
         n_bad++;
         $display("FAIL reset_a got csx/dcx/wrx/rdx=%b%b%b%b d=%h cmpl/busy/err=%b%b%b want 1111 0000 000",
                  csx, dcx, wrx, rdx, d, cmpl, busy, err);
      end
      n_cmp++;
      if ({b_csx, b_dcx, b_wrx, b_rdx, b_d, b_cmpl, b_busy, b_err} !== {4'b1111, 16'h0000, 3'b000}) begin
         n_bad++;
         $display("FAIL reset_b got csx/dcx/wrx/rdx=%b%b%b%b d=%h want 1111 0000", b_csx, b_dcx, b_wrx, b_rdx, b_d);
      end
      @(posedge clk);
      #1;
      nres = 1'b1;
      tick();
   endtask

   task automatic test_single_cmd();
      data_lines = 16'h0011;
      cmd = 1'b1;
      for (int k = 1; k <= 7; k++) begin
         tick();
         cmd = 1'b0;
         n_cmp++;
         if ({csx, wrx, cmpl, busy, dcx, d} !== {wave(k, 1, 2, 2, 1), 1'b1, DCX_CMD, 16'h0011}) begin
            n_bad++;
            $display("FAIL single_cmd k=%0d got csx/wrx/cmpl/busy=%b%b%b%b dcx=%b d=%h want %b1 0 0011",
                     k, csx, wrx, cmpl, busy, dcx, d, wave(k, 1, 2, 2, 1));
         end
      end
      tick();
      n_cmp++;
      if ({cmpl, busy, csx} !== 3'b001) begin
         n_bad++;
         $display("FAIL cmd_after_done got cmpl/busy/csx=%b%b%b want 001", cmpl, busy, csx);
      end
   endtask

   task automatic test_single_data();
      data_lines = 16'h0042;
      data = 1'b1;
      for (int k = 1; k <= 7; k++) begin
         tick();
         data = 1'b0;
         data_lines = 16'hFFFF;
         n_cmp++;
         if ({csx, wrx, cmpl, busy, dcx, d} !== {wave(k, 1, 2, 2, 1), 1'b1, DCX_DATA, 16'h0042}) begin
            n_bad++;
            $display("FAIL single_data k=%0d got csx/wrx/cmpl/busy=%b%b%b%b dcx=%b d=%h want %b1 1 0042",
                     k, csx, wrx, cmpl, busy, dcx, d, wave(k, 1, 2, 2, 1));
         end
      end
      repeat (3) tick();
      n_cmp++;
      if ({d, dcx, busy, csx, wrx} !== {16'h0042, 4'b1011}) begin
         n_bad++;
         $display("FAIL data_hold got d=%h dcx=%b busy=%b csx=%b wrx=%b want 0042 1 0 1 1", d, dcx, busy, csx, wrx);
      end
   endtask

   task automatic test_back_to_back();
      bus_word_t words [9] = '{16'h0011, 16'h00D0, 16'h0007, 16'h0042, 16'h0018,
                               16'h00D1, 16'h0000, 16'h0007, 16'h0010};
      logic      is_cmd [9] = '{1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0};
      int        pulses = 0;
      logic      prev_wrx = 1'b1;
      for (int i = 0; i < 9; i++) begin
         data_lines = words[i];
         cmd = is_cmd[i];
         data = !is_cmd[i];
         for (int k = 1; k <= 7; k++) begin
            tick();
            cmd = 1'b0;
            data = 1'b0;
            if (prev_wrx && !wrx) pulses++;
            prev_wrx = wrx;
            n_cmp++;
            if ({csx, wrx, cmpl, busy} !== {wave(k, 1, 2, 2, 1), 1'b1}) begin
               n_bad++;
               $display("FAIL b2b_wave word=%0d k=%0d got csx/wrx/cmpl/busy=%b%b%b%b want %b1",
                        i, k, csx, wrx, cmpl, busy, wave(k, 1, 2, 2, 1));
            end
            if (k == 2) begin
               n_cmp++;
               if ({dcx, d} !== {!is_cmd[i], words[i]}) begin
                  n_bad++;
                  $display("FAIL b2b_word word=%0d got dcx=%b d=%h want dcx=%b d=%h", i, dcx, d, !is_cmd[i], words[i]);
               end
            end
         end
      end
      tick();
      n_cmp++;
      if (pulses !== 9 || err !== 1'b0 || busy !== 1'b0) begin
         n_bad++;
         $display("FAIL b2b_summary got pulses=%0d err=%b busy=%b want 9 0 0", pulses, err, busy);
      end
   endtask

   task automatic test_strobe_collision();
      bus_word_t wa, wb;
      wa = 16'($urandom_range(0, 65535));
      wb = ~wa;
      data_lines = wa;
      cmd = 1'b1;
      for (int k = 1; k <= 7; k++) begin
         tick();
         cmd = 1'b0;
         data = 1'b0;
         n_cmp++;
         if ({csx, wrx, cmpl, dcx, d} !== {wave(k, 1, 2, 2, 1), DCX_CMD, wa}) begin
            n_bad++;
            $display("FAIL collide k=%0d got csx/wrx/cmpl=%b%b%b dcx=%b d=%h want %b 0 %h",
                     k, csx, wrx, cmpl, dcx, d, wave(k, 1, 2, 2, 1), wa);
         end
         if (k == 2) begin
            data_lines = wb;
            data = 1'b1;
         end
      end
      repeat (4) tick();
      n_cmp++;
      if ({err, d, busy} !== {1'b1, wa, 1'b0}) begin
         n_bad++;
         $display("FAIL collide_err got err=%b d=%h busy=%b want 1 %h 0", err, d, busy, wa);
      end
   endtask

   task automatic test_reset_midwrite();
      data_lines = 16'h5A5A;
      cmd = 1'b1;
      tick();
      cmd = 1'b0;
      tick();
      nres = 1'b0;
      #1;
      n_cmp++;
      if ({csx, dcx, wrx, d, cmpl, busy, err} !== {3'b111, 16'h0000, 3'b000}) begin
         n_bad++;
         $display("FAIL async_reset got csx/dcx/wrx=%b%b%b d=%h cmpl/busy/err=%b%b%b want 111 0000 000",
                  csx, dcx, wrx, d, cmpl, busy, err);
      end
      repeat (2) tick();
      nres = 1'b1;
      for (int k = 1; k <= 8; k++) begin
         tick();
         n_cmp++;
         if ({cmpl, busy, csx, wrx} !== 4'b0011) begin
            n_bad++;
            $display("FAIL no_cmpl_after_abort k=%0d got cmpl/busy/csx/wrx=%b%b%b%b want 0011", k, cmpl, busy, csx, wrx);
         end
      end
      data_lines = 16'h0007;
      data = 1'b1;
      for (int k = 1; k <= 7; k++) begin
         tick();
         data = 1'b0;
         n_cmp++;
         if ({csx, wrx, cmpl, dcx, d} !== {wave(k, 1, 2, 2, 1), DCX_DATA, 16'h0007}) begin
            n_bad++;
            $display("FAIL post_reset k=%0d got csx/wrx/cmpl=%b%b%b dcx=%b d=%h want %b 1 0007",
                     k, csx, wrx, cmpl, dcx, d, wave(k, 1, 2, 2, 1));
         end
      end
   endtask

   task automatic test_both_strobes();
      tick();
      data_lines = 16'h00D0;
      cmd = 1'b1;
      data = 1'b1;
      for (int k = 1; k <= 7; k++) begin
         tick();
         cmd = 1'b0;
         data = 1'b0;
         n_cmp++;
         if ({csx, wrx, cmpl, dcx, d, err} !== {wave(k, 1, 2, 2, 1), DCX_CMD, 16'h00D0, 1'b1}) begin
            n_bad++;
            $display("FAIL both_strobes k=%0d got csx/wrx/cmpl=%b%b%b dcx=%b d=%h err=%b want %b 0 00d0 1",
                     k, csx, wrx, cmpl, dcx, d, err, wave(k, 1, 2, 2, 1));
         end
      end
   endtask

   task automatic test_param_timing();
      int low_cnt = 0;
      bus_word_t w;
      w = 16'($urandom_range(0, 65535));
      tick();
      data_lines = w;
      b_cmd = 1'b1;
      for (int k = 1; k <= 16; k++) begin
         tick();
         b_cmd = 1'b0;
         if (!b_wrx) low_cnt++;
         n_cmp++;
         if ({b_csx, b_wrx, b_cmpl, b_busy} !== {wave(k, 3, 5, 4, 2), (k <= 15)}) begin
            n_bad++;
            $display("FAIL slow_wave k=%0d got csx/wrx/cmpl/busy=%b%b%b%b want %b%b",
                     k, b_csx, b_wrx, b_cmpl, b_busy, wave(k, 3, 5, 4, 2), (k <= 15));
         end
      end
      n_cmp++;
      if (low_cnt !== 5 || b_d !== w) begin
         n_bad++;
         $display("FAIL slow_summary got wrx_low=%0d d=%h want 5 %h", low_cnt, b_d, w);
      end
   endtask

   task automatic test_random();
      int        k = 100;
      bus_word_t last_d = '0;
      logic      last_dcx = 1'b1;
      logic      go;
      bus_word_t w;
      logic      t;
      nres = 1'b0;
      repeat (2) tick();
      nres = 1'b1;
      for (int c = 0; c < 400; c++) begin
         go = (k >= 7) && ($urandom_range(0, 2) != 0);
         w  = 16'($urandom_range(0, 65535));
         t  = 1'($urandom_range(0, 1));
         data_lines = w;
         cmd  = go && !t;
         data = go && t;
         tick();
         cmd  = 1'b0;
         data = 1'b0;
         if (go) begin
            k = 1;
            last_d = w;
            last_dcx = t;
         end else if (k < 100) begin
            k++;
         end
         n_cmp++;
         if ({csx, wrx, cmpl, busy, dcx, d, err} !==
             {wave(k, 1, 2, 2, 1), (k <= 7), last_dcx, last_d, 1'b0}) begin
            n_bad++;
            $display("FAIL random c=%0d k=%0d got csx/wrx/cmpl/busy=%b%b%b%b dcx=%b d=%h err=%b want %b%b %b %h 0",
                     c, k, csx, wrx, cmpl, busy, dcx, d, err, wave(k, 1, 2, 2, 1), (k <= 7), last_dcx, last_d);
         end
      end
   endtask

   initial begin
      test_reset();
      test_single_cmd();
      test_single_data();
      test_back_to_back();
      test_strobe_collision();
      test_reset_midwrite();
      test_both_strobes();
      test_param_timing();
      test_random();
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end

endmodule
